// File: rtl/clock_divider_gen.sv
// Two-rate glitch-free clock divider; rate changes land only on falling edges of clock_divided.
// Optional tick counter port divided_count is enabled with CLOCK_DIVIDER_CYCLE_COUNT_EN.
module clock_divider_gen #(
  parameter int unsigned FAST_HALF = 2,
  parameter int unsigned SLOW_HALF = 50000000
) (
  input  logic        clock_100mhz,
  input  logic        reset_n,
  input  logic        pll_locked,
  input  logic        slow_mode,
  output logic        clock_divided,
  output logic        divided_tick,
  output logic        mode_active
`ifdef CLOCK_DIVIDER_CYCLE_COUNT_EN
  ,
  output logic [31:0] divided_count
`endif
);

  localparam int unsigned CNT_W = $clog2(SLOW_HALF) + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   counter, counter_nxt;
  logic [CNT_W-1:0]   half_m1;
  logic               clk_div_nxt;
  logic               tick_nxt;
  logic               mode_nxt;
  logic               slow_meta, slow_s;
  logic               locked_meta, locked_s;

  // Two-flop synchronizers for the asynchronous control inputs.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n) begin
      slow_meta   <= 1'b0;
      slow_s      <= 1'b0;
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      slow_meta   <= slow_mode;
      slow_s      <= slow_meta;
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  assign half_m1 = mode_active ? CNT_W'(SLOW_HALF - 1) : CNT_W'(FAST_HALF - 1);

  // State and registered outputs.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      counter       <= '0;
      clock_divided <= 1'b0;
      divided_tick  <= 1'b0;
      mode_active   <= 1'b1;
    end else begin
      state         <= state_nxt;
      counter       <= counter_nxt;
      clock_divided <= clk_div_nxt;
      divided_tick  <= tick_nxt;
      mode_active   <= mode_nxt;
    end
  end

  // Next-state logic; the mode is only re-sampled on a falling edge so the new
  // half-period always starts with a complete low phase.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    clk_div_nxt = clock_divided;
    tick_nxt    = 1'b0;
    mode_nxt    = mode_active;
    case (state)
      ST_IDLE: begin
        clk_div_nxt = 1'b0;
        counter_nxt = '0;
        mode_nxt    = slow_s;
        if (locked_s) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_nxt   = ST_IDLE;
          clk_div_nxt = 1'b0;
          counter_nxt = '0;
        end else if (counter == half_m1) begin
          counter_nxt = '0;
          clk_div_nxt = ~clock_divided;
          if (!clock_divided) tick_nxt = 1'b1;
          else                mode_nxt = slow_s;
        end else begin
          counter_nxt = CNT_W'(counter + 1'b1);
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        clk_div_nxt = 1'b0;
        counter_nxt = '0;
      end
    endcase
  end

`ifdef CLOCK_DIVIDER_CYCLE_COUNT_EN
  logic [31:0] count_q;

  // Free-running tick count; survives loss of lock, wraps naturally.
  always_ff @(posedge clock_100mhz) begin
    if (!reset_n)      count_q <= '0;
    else if (tick_nxt) count_q <= count_q + 32'd1;
  end

  assign divided_count = count_q;
`endif

endmodule

// File: tb/tb_clock_divider_gen.sv
// Directed bench for clock_divider_gen with FAST_HALF=2, SLOW_HALF=5.
module tb_clock_divider_gen;

  logic clock_100mhz = 1'b0;
  logic reset_n      = 1'b0;
  logic pll_locked   = 1'b1;
  logic slow_mode    = 1'b1;
  logic clock_divided;
  logic divided_tick;
  logic mode_active;
`ifdef CLOCK_DIVIDER_CYCLE_COUNT_EN
  logic [31:0] divided_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock_100mhz = ~clock_100mhz;

  clock_divider_gen #(.FAST_HALF(2), .SLOW_HALF(5)) dut (
    .clock_100mhz (clock_100mhz),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .slow_mode    (slow_mode),
    .clock_divided(clock_divided),
    .divided_tick (divided_tick),
    .mode_active  (mode_active)
`ifdef CLOCK_DIVIDER_CYCLE_COUNT_EN
    ,
    .divided_count(divided_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_100mhz);
    #1;
  endtask

  // Advance until clock_divided equals val (bounded); reports whether it was found.
  task automatic wait_for(input string tag, input logic val);
    int n = 0;
    while (clock_divided !== val && n < 100) begin
      cyc();
      n++;
    end
    check(tag, 32'(clock_divided === val), 32'd1);
  endtask

  // Length of the current run of clock_divided == val, ending on the first differing sample.
  task automatic count_run(input logic val, output int n);
    n = 0;
    while (clock_divided === val && n < 100) begin
      n++;
      cyc();
    end
  endtask

  task automatic wait_mode(input string tag, input logic val);
    int n = 0;
    while (mode_active !== val && n < 60) begin
      cyc();
      n++;
    end
    check(tag, 32'(mode_active), 32'(val));
  endtask

  int n;
  int ticks;

  initial begin
    // Test 1: reset, then slow-mode 5/5 waveform
    #1;
    repeat (3) cyc();
    check("rst_clk", 32'(clock_divided), 32'd0);
    check("rst_tick", 32'(divided_tick), 32'd0);
    check("rst_mode", 32'(mode_active), 32'd1);
    reset_n = 1'b1;
    wait_for("t1_first_high", 1'b1);
    check("t1_tick_first_high", 32'(divided_tick), 32'd1);
    count_run(1'b1, n); check("t1_high", 32'(n), 32'd5);
    count_run(1'b0, n); check("t1_low", 32'(n), 32'd5);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (divided_tick) ticks++;
      cyc();
    end
    check("t1_ticks_20cyc", 32'(ticks), 32'd2);

    // Test 2: slow->fast requested in high phase
    wait_for("t2_high", 1'b1);
    check("t2_mode_before", 32'(mode_active), 32'd1);
    slow_mode = 1'b0;
    count_run(1'b1, n); check("t2_high_completes", 32'(n), 32'd5);
    check("t2_mode_at_fall", 32'(mode_active), 32'd0);
    count_run(1'b0, n); check("t2_fast_low", 32'(n), 32'd2);
    count_run(1'b1, n); check("t2_fast_high", 32'(n), 32'd2);
    count_run(1'b0, n); check("t2_fast_low2", 32'(n), 32'd2);

    // Test 3: back to slow, then a 3-cycle glitch on slow_mode within a high phase
    slow_mode = 1'b1;
    wait_mode("t3_mode_slow", 1'b1);
    check("t3_switch_on_fall", 32'(clock_divided), 32'd0);
    repeat (4) cyc();
    check("t3_low5", 32'(clock_divided), 32'd0);
    slow_mode = 1'b0;
    cyc();
    check("t3_high_start", 32'(clock_divided), 32'd1);
    repeat (2) cyc();
    slow_mode = 1'b1;
    count_run(1'b1, n); check("t3_high_rest", 32'(n), 32'd3);
    check("t3_mode_kept", 32'(mode_active), 32'd1);
    count_run(1'b0, n); check("t3_low", 32'(n), 32'd5);
    count_run(1'b1, n); check("t3_high", 32'(n), 32'd5);

    // Test 4: lock loss mid high phase, then relock
    wait_for("t4_high", 1'b1);
    cyc();
    pll_locked = 1'b0;
    n = 0;
    while (clock_divided === 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("t4_drop_latency", 32'(n), 32'd3);
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      if (clock_divided) ticks++;
      cyc();
    end
    check("t4_held_low", 32'(ticks), 32'd0);
    pll_locked = 1'b1;
    n = 0;
    while (clock_divided !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check("t4_relock_to_high", 32'(n), 32'd8);
    check("t4_relock_tick", 32'(divided_tick), 32'd1);
    count_run(1'b1, n); check("t4_relock_high", 32'(n), 32'd5);

    // Test 5: reset mid-run in fast mode
    slow_mode = 1'b0;
    wait_mode("t5_mode_fast", 1'b0);
    wait_for("t5_high", 1'b1);
    cyc();
    reset_n = 1'b0;
    cyc();
    check("t5_rst_clk", 32'(clock_divided), 32'd0);
    check("t5_rst_tick", 32'(divided_tick), 32'd0);
    check("t5_rst_mode", 32'(mode_active), 32'd1);
    reset_n = 1'b1;
    n = 0;
    while (clock_divided !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    check("t5_restart_latency", 32'(n), 32'd5);
    check("t5_restart_mode", 32'(mode_active), 32'd0);
    count_run(1'b1, n); check("t5_fast_high", 32'(n), 32'd2);
    count_run(1'b0, n); check("t5_fast_low", 32'(n), 32'd2);

`ifdef CLOCK_DIVIDER_CYCLE_COUNT_EN
    // Test 6: tick counter and wrap
    reset_n = 1'b0;
    cyc();
    check("t6_rst_count", divided_count, 32'd0);
    reset_n = 1'b1;
    ticks = 0;
    n = 0;
    while (ticks < 7 && n < 200) begin
      cyc();
      n++;
      if (divided_tick) ticks++;
    end
    check("t6_count7", divided_count, 32'd7);
    cyc();
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      cyc();
      while (divided_tick !== 1'b1 && n < 50) begin
        cyc();
        n++;
      end
      check("t6_wrap", divided_count, 32'(k));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
